// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST sequencer: FSM states,
// LFSR feedback mask, corner vector table and the "no error seen" marker.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } vec_t;

    localparam logic [15:0] LFSR_MASK       = 16'hB400;
    localparam logic [8:0]  FIRST_ERR_NONE  = 9'h1FF;
    localparam int          NUM_CORNER_VECS = 4;

    // Sum extremes: zero, full carry chain, carry-in ripple, top-bit carry only.
    localparam vec_t CORNER_VECS [NUM_CORNER_VECS] = '{
        '{a: 8'h00, b: 8'h00, cin: 1'b0},
        '{a: 8'hFF, b: 8'hFF, cin: 1'b1},
        '{a: 8'hFF, b: 8'h00, cin: 1'b1},
        '{a: 8'h80, b: 8'h80, cin: 1'b0}
    };

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/adder_bist_sequencer_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous seed load and
// advance enable; load wins over advance.
module bist_lfsr16
    import adder_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (load_i) begin
            state_q <= SEED;
        end else if (adv_i) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/adder_bist_sequencer.sv
// BIST initiator for the 8-bit adder: drives vectors, samples {cout,sum},
// counts mismatches. ADDER_BIST_CORNER_EN prepends four fixed corner vectors.
//
// state    | meaning
// IDLE     | waiting for start after reset
// DRIVE    | register operands of the current vector
// WAIT     | let the adder settle for SETTLE_CYCLES
// CHECK    | compare adder result, step to next vector or finish
// DONE     | results and last operands held; start reruns
module adder_bist_sequencer
    import adder_bist_pkg::*;
#(
    parameter int          NUM_VECTORS   = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       cin,
    input  logic [7:0] sum_in,
    input  logic       cout_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [8:0] first_err_idx
);

`ifdef ADDER_BIST_CORNER_EN
    localparam int NUM_CORNER = NUM_CORNER_VECS;
`else
    localparam int NUM_CORNER = 0;
`endif
    localparam logic [8:0] LAST_IDX = 9'(NUM_VECTORS + NUM_CORNER - 1);
    localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic        cin_q, cin_d;
    logic [7:0]  err_q, err_d;
    logic [8:0]  first_q, first_d;
    logic [8:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lfsr_load, lfsr_adv;
    logic [15:0] lfsr;
    vec_t        vec_cur;
    logic        vec_is_random;
    logic [8:0]  expected;
    logic        mismatch;

    bist_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .state_o (lfsr)
    );

    always_comb begin
        vec_cur       = '{a: lfsr[15:8], b: lfsr[7:0], cin: idx_q[0]};
        vec_is_random = 1'b1;
`ifdef ADDER_BIST_CORNER_EN
        // The LFSR stays parked on the seed until the corners are done.
        if (idx_q < 9'(NUM_CORNER_VECS)) begin
            vec_cur       = CORNER_VECS[idx_q[1:0]];
            vec_is_random = 1'b0;
        end
`endif
    end

    assign expected = 9'(op_a_q) + 9'(op_b_q) + 9'(cin_q);
    assign mismatch = (expected != {cout_in, sum_in});

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cin_d     = cin_q;
        err_d     = err_q;
        first_d   = first_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        if (ena) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_DRIVE;
                        err_d     = '0;
                        first_d   = FIRST_ERR_NONE;
                        idx_d     = '0;
                        lfsr_load = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    {op_a_d, op_b_d, cin_d} = vec_cur;
                    cnt_d   = SETTLE;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (first_q == FIRST_ERR_NONE) begin
                            first_d = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d    = idx_q + 9'd1;
                        lfsr_adv = vec_is_random;
                        state_d  = ST_DRIVE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cin_q   <= 1'b0;
            err_q   <= '0;
            first_q <= FIRST_ERR_NONE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cin_q   <= cin_d;
            err_q   <= err_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign cin           = cin_q;
    assign busy          = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_q == 8'd0);
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist_sequencer.sv
// Bench for adder_bist_sequencer: a short-run and a full-run instance share
// reset/enable; adder models with selectable faults; results vs. a vector-list model.
module tb_adder_bist_sequencer;

    localparam int N_S = 2;
    localparam int S_S = 1;
    localparam int P_S = 2 + S_S;
    localparam int N_F = 256;
    localparam int S_F = 3;
    localparam int P_F = 2 + S_F;
`ifdef ADDER_BIST_CORNER_EN
    localparam int NC = 4;
`else
    localparam int NC = 0;
`endif
    localparam int NT_S = N_S + NC;
    localparam int NT_F = N_F + NC;

    logic       clk = 1'b0;
    logic       rst_n, ena, start_s, start_f;
    logic [7:0] op_a_s, op_b_s, sum_s, err_s;
    logic       cin_s, cout_s, busy_s, done_s, pass_s;
    logic [8:0] first_s;
    logic [7:0] op_a_f, op_b_f, sum_f, err_f;
    logic       cin_f, cout_f, busy_f, done_f, pass_f;
    logic [8:0] first_f;
    int         fault_s = 0;
    int         fault_f = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [16:0] ref_vec [NT_F];

    always #5 clk = ~clk;

    function automatic logic [8:0] apply_fault(input logic [8:0] good, input int mode);
        case (mode)
            1:       return good & 9'h1FE;
            2:       return good ^ 9'h1FF;
            default: return good;
        endcase
    endfunction

    assign {cout_s, sum_s} = apply_fault(9'(op_a_s) + 9'(op_b_s) + 9'(cin_s), fault_s);
    assign {cout_f, sum_f} = apply_fault(9'(op_a_f) + 9'(op_b_f) + 9'(cin_f), fault_f);

    adder_bist_sequencer #(.NUM_VECTORS(N_S), .LFSR_SEED(16'hACE1), .SETTLE_CYCLES(S_S)) u_small (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_s),
        .op_a(op_a_s), .op_b(op_b_s), .cin(cin_s), .sum_in(sum_s), .cout_in(cout_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .first_err_idx(first_s)
    );

    adder_bist_sequencer #(.NUM_VECTORS(N_F), .LFSR_SEED(16'hACE1), .SETTLE_CYCLES(S_F)) u_full (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_f),
        .op_a(op_a_f), .op_b(op_b_f), .cin(cin_f), .sum_in(sum_f), .cout_in(cout_f),
        .busy(busy_f), .done(done_f), .pass(pass_f), .err_count(err_f), .first_err_idx(first_f)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Vector list straight from the rules: corners first (optional), then LFSR words.
    function automatic void build_vectors();
        logic [15:0] r;
        r = 16'hACE1;
        for (int k = 0; k < NT_F; k++) begin
            if (k < NC) begin
                case (k)
                    0:       ref_vec[k] = {8'h00, 8'h00, 1'b0};
                    1:       ref_vec[k] = {8'hFF, 8'hFF, 1'b1};
                    2:       ref_vec[k] = {8'hFF, 8'h00, 1'b1};
                    default: ref_vec[k] = {8'h80, 8'h80, 1'b0};
                endcase
            end else begin
                ref_vec[k] = {r, 1'(k)};
                r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
            end
        end
    endfunction

    function automatic void expected_result(input int upto, input int mode,
                                            output int errs, output int first);
        logic [8:0] good;
        errs  = 0;
        first = 'h1FF;
        for (int k = 0; k < upto; k++) begin
            good = 9'(ref_vec[k][16:9]) + 9'(ref_vec[k][8:1]) + 9'(ref_vec[k][0]);
            if (apply_fault(good, mode) != good) begin
                if (errs < 255) errs++;
                if (first == 'h1FF) first = k;
            end
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ops_s"}, 32'({op_a_s, op_b_s, cin_s}), 32'd0);
        check_eq({tag, "_ops_f"}, 32'({op_a_f, op_b_f, cin_f}), 32'd0);
        check_eq({tag, "_flags_s"}, 32'({busy_s, done_s, pass_s}), 32'd0);
        check_eq({tag, "_flags_f"}, 32'({busy_f, done_f, pass_f}), 32'd0);
        check_eq({tag, "_err_f"}, 32'(err_f), 32'd0);
        check_eq({tag, "_first_f"}, 32'(first_f), 32'h1FF);
        check_eq({tag, "_first_s"}, 32'(first_s), 32'h1FF);
    endtask

    // Starts both instances; ena low for drop_len cycles from cycle drop_at,
    // optional extra start to the full instance at spur_at, optional reset
    // when the full instance has made rst_at enabled steps.
    task automatic run_both(input int fs, input int ff, input int drop_at, input int drop_len,
                            input int spur_at, input int rst_at, output int tot_f);
        int act, tot, done_s_at, done_f_at, e, f;
        fault_s = fs;
        fault_f = ff;
        act = 0; tot = 0; done_s_at = -1; done_f_at = -1; tot_f = -1;
        @(negedge clk);
        ena = 1'b1; start_s = 1'b1; start_f = 1'b1;
        @(negedge clk);
        start_s = 1'b0; start_f = 1'b0;
        for (int step = 0; step < 4000; step++) begin
            ena     = !(drop_len > 0 && tot >= drop_at && tot < drop_at + drop_len);
            start_f = (tot == spur_at);
            @(posedge clk);
            tot++;
            if (ena) act++;
            @(negedge clk);
            start_f = 1'b0;
            if (rst_at > 0 && act == rst_at) begin
                expected_result(rst_at / P_F, ff, e, f);
                check_eq("pre_rst_err_f", 32'(err_f), 32'(e));
                check_eq("pre_rst_busy_f", 32'(busy_f), 32'd1);
                rst_n = 1'b0;
                #1;
                check_reset_vals("midrun_rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done_s_at < 0) begin
                if (act >= 1 && (act - 1) % P_S == 0 && (act - 1) / P_S < NT_S)
                    check_eq("vec_s", 32'({op_a_s, op_b_s, cin_s}), 32'(ref_vec[(act - 1) / P_S]));
                if (done_s) begin
                    done_s_at = tot;
                    check_eq("done_act_s", act, NT_S * P_S);
                end
            end
            if (done_f_at < 0) begin
                if (act >= 1 && (act - 1) % P_F == 0 && (act - 1) / P_F < NT_F)
                    check_eq("vec_f", 32'({op_a_f, op_b_f, cin_f}), 32'(ref_vec[(act - 1) / P_F]));
                if (done_f) begin
                    done_f_at = tot;
                    check_eq("done_act_f", act, NT_F * P_F);
                end
            end
            if (done_s_at >= 0 && done_f_at >= 0) break;
        end
        ena = 1'b1;
        check_eq("timeout_s", 32'(done_s_at >= 0), 32'd1);
        check_eq("timeout_f", 32'(done_f_at >= 0), 32'd1);
        tot_f = done_f_at;
        expected_result(NT_S, fs, e, f);
        check_eq("err_s", 32'(err_s), 32'(e));
        check_eq("first_s", 32'(first_s), 32'(f));
        check_eq("pass_s", 32'({done_s, pass_s}), 32'({1'b1, e == 0}));
        check_eq("held_ops_s", 32'({op_a_s, op_b_s, cin_s}), 32'(ref_vec[NT_S - 1]));
        expected_result(NT_F, ff, e, f);
        check_eq("err_f", 32'(err_f), 32'(e));
        check_eq("first_f", 32'(first_f), 32'(f));
        check_eq("pass_f", 32'({done_f, pass_f}), 32'({1'b1, e == 0}));
        check_eq("held_ops_f", 32'({op_a_f, op_b_f, cin_f}), 32'(ref_vec[NT_F - 1]));
    endtask

    initial begin
        int base_tot, t;
        build_vectors();
        rst_n = 1'b0; ena = 1'b1; start_s = 1'b0; start_f = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("in_rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");

        ena = 1'b0; start_s = 1'b1; start_f = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0; start_f = 1'b0; ena = 1'b1;
        @(negedge clk);
        check_eq("ena_low_start", 32'({busy_s, busy_f}), 32'd0);

        run_both(0, 0, -1, 0, -1, 0, base_tot);
        check_eq("base_run_len_f", base_tot, NT_F * P_F);
        run_both(1, 1, -1, 0, -1, 0, t);
        run_both(2, 2, -1, 0, 10 + $urandom_range(0, 200), 0, t);
        check_eq("spur_start_len_f", t, base_tot);
        run_both(0, 0, 7, 5, -1, 0, t);
        check_eq("ena_drop_len_f", t, base_tot + 5);
        run_both(2, 2, -1, 0, -1, 10 * P_F + 1 + S_F, t);
        run_both(0, 0, 2 + $urandom_range(0, 600), 1 + $urandom_range(0, 9), -1, 0, t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_bist_sequencer.md
Name: adder_bist_sequencer

Overview:
Built-in self-test initiator for the 8-bit full adder: generates operand/carry vectors, drives them onto the adder inputs, samples {cout, sum} and checks against an internally computed expected value. It is the stimulus-and-check end of the adder interface and sits beside the adder inside the tile. Pass/fail status and error diagnostics are mapped to the output pins.

Parameters:
NUM_VECTORS, 256, pseudo-random vectors per run (legal 1..256)
LFSR_SEED, 16'hACE1, LFSR value loaded at each run start (nonzero)
SETTLE_CYCLES, 1, wait cycles between driving operands and sampling result (legal 1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  tile enable; low freezes FSM and all registers
start  in  1  single-cycle run request, honoured only in IDLE or DONE
op_a  out  8  operand A to adder, registered
op_b  out  8  operand B to adder, registered
cin  out  1  carry-in to adder, registered
sum_in  in  8  adder sum
cout_in  in  1  adder carry-out
busy  out  1  high in DRIVE/WAIT/CHECK
done  out  1  high in DONE
pass  out  1  done and err_count==0
err_count  out  8  mismatches this run, saturates at 255
first_err_idx  out  9  vector index of first mismatch; 9'h1FF if none

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Reset values: op_a=0, op_b=0, cin=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=9'h1FF, state=IDLE, lfsr=LFSR_SEED, idx=0.
- LFSR: 16-bit Galois, right shift, mask 16'hB400 (if lsb=1: next = (lfsr>>1) ^ 16'hB400, else lfsr>>1).
- Random vector k: op_a=lfsr[15:8], op_b=lfsr[7:0], cin=idx[0]; LFSR advances once per vector.
- Expected = op_a + op_b + cin, 9-bit zero-extended; compared to {cout_in, sum_in}.
- FSM (all transitions gated by ena=1):
  IDLE: start -> DRIVE; clears err_count, first_err_idx, idx; loads LFSR_SEED.
  DRIVE (1 cycle): registers op_a/op_b/cin for current vector -> WAIT, settle counter = SETTLE_CYCLES.
  WAIT: decrement; at 1 -> CHECK.
  CHECK (1 cycle): compare; on mismatch err_count++ (saturating), first_err_idx=idx if still 9'h1FF. If idx==last -> DONE, else idx++, advance LFSR -> DRIVE.
  DONE: done=1, outputs held; start -> same as IDLE start (rerun).
- Per-vector latency: 2+SETTLE_CYCLES cycles. start to done (SETTLE_CYCLES=1, N vectors): 3N+1 cycles.
- start while busy: ignored. start and ena low in same cycle: ignored.
- ena low mid-run: all state frozen; resumes exactly where stopped.
- Reset mid-run: immediate return to reset values; no partial result retained.
- op_a/op_b/cin stay at last driven vector after DONE.

Optional Feature:
ADDER_BIST_CORNER_EN: when defined, four fixed corner vectors run first, indices 0..3: (00,00,0), (FF,FF,1), (FF,00,1), (80,80,0); random vectors follow at indices 4..NUM_VECTORS+3 (idx[0] still sets cin, LFSR not advanced during corners). Undefined: random vectors only, indices 0..NUM_VECTORS-1.

Decomposition:
- Package adder_bist_pkg: state enum (IDLE, DRIVE, WAIT, CHECK, DONE), LFSR mask 16'hB400, corner vector constant array, FIRST_ERR_NONE=9'h1FF.
- Sub-module bist_lfsr16 (seed load, advance enable, 16-bit state out).

Test Plan:
- Reset, NUM_VECTORS=2, ideal adder model, start pulse -> vector 0 A=AC B=E1 cin=0 expect 0x18D; vector 1 A=E2 B=70 cin=1 expect 0x153; done at cycle 7, pass=1, err_count=0, first_err_idx=1FF.
- Adder model forces sum bit 0 stuck at 0, NUM_VECTORS=256 -> pass=0, err_count = count of odd expected sums (saturated at 255), first_err_idx = first such index (0 here, since 0x18D is odd).
- Drop ena for 5 cycles during WAIT -> done asserts exactly 5 cycles later than uninterrupted run; results identical.
- Assert rst_n low during CHECK of vector 10 -> all outputs to reset values asynchronously; new start reproduces vector 0 A=AC B=E1.
- start pulsed while busy -> ignored; start in DONE -> counters cleared, rerun reproduces identical vectors.
- ADDER_BIST_CORNER_EN defined -> first four vectors (00,00,0),(FF,FF,1),(FF,00,1),(80,80,0) expect 000,1FF,100,100; index 4 is A=AC B=E1 cin=0.
